rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
- Parametrised N-way round-robin arbiter with ready/valid handshakes on every port.
- Next generation of the fixed 4-input round-robin arbiter. Adds configurable channel count and data width.
- Adds burst locking: once a multi-beat transfer starts, the grant stays on that input until its last beat, or until a programmable beat limit forces release.
- Sits between N producers and one shared downstream consumer (memory port, network link).

Parameters:
- N, 4, number of input channels; legal range 2..16.
- W, 8, payload width in bits.
- MAX_BEATS, 0, forced-release limit in beats per locked burst; 0 = unlimited; legal range 0 or 2..255.
- CW, derived = max(1, clog2(N)), width of io_chosen. Not user-settable.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in_valid  input  N  per-channel valid.
- io_in_bits  input  N*W  channel i payload in bits [i*W +: W].
- io_in_last  input  N  per-channel last-beat flag, qualified by valid.
- io_in_ready  output  N  per-channel ready.
- io_out_valid  output  1  output valid.
- io_out_bits  output  W  output payload.
- io_out_last  output  1  last flag of the granted channel, or forced release.
- io_out_ready  input  1  downstream ready.
- io_chosen  output  CW  index of the granted channel.
- io_locked  output  1  registered; 1 while a burst lock is held.

Behaviour:
- State registers:
  - ptr [CW]: last granted index, reset 0.
  - locked [1]: reset 0.
  - lock_idx [CW]: reset 0.
  - beat_cnt [8]: reset 0.
- Reset is synchronous. Asserting reset mid-burst drops the lock and restores all registers to reset values on the next edge.
- Outputs during reset follow the combinational rules below using the reset register values.
- Unlocked grant (combinational, zero latency):
  - Choose the lowest index i > ptr with io_in_valid[i].
  - If none, choose the lowest index i with io_in_valid[i].
  - If no input is valid, chosen = N-1.
- Locked grant: chosen = lock_idx regardless of other valids.
- Output path:
  - io_out_valid = io_in_valid[chosen].
  - io_out_bits = bits of chosen.
  - io_out_last = io_in_last[chosen] OR force.
  - io_chosen = chosen.
  - io_in_ready[i] = io_out_ready AND (chosen == i). All other readys are 0.
- fire = io_out_valid AND io_out_ready.
- force = locked AND (MAX_BEATS != 0) AND (beat_cnt == MAX_BEATS-1).
- On fire:
  - ptr <= chosen.
  - If io_in_last[chosen] OR force: locked <= 0, beat_cnt <= 0.
  - Else: locked <= 1, lock_idx <= chosen, beat_cnt <= beat_cnt+1 (saturating at 255).
- No fire: all state holds. A locked channel that drops valid stalls the output; no other channel is served meanwhile.
- Single-beat transfers (last=1 on first beat) never lock and behave exactly as a plain round-robin arbiter.
- After release (natural or forced), the next grant searches from ptr = released index, so the released channel has lowest priority.
- After a forced release, the remaining beats of that channel's burst re-arbitrate as a new burst.
- io_out_last is asserted on the forced beat so downstream sees a burst boundary.
- io_out_valid has no combinational dependency on io_out_ready. io_in_ready does depend on io_out_ready.
- ptr wrap-around: with ptr = N-1, the search "i > ptr" is empty, so the lowest valid index wins.

Test Plan:
- Fairness, N=4, W=8, all valid, last=1, out_ready=1 for 8 cycles: chosen sequence 1,2,3,0,1,2,3,0; each io_in_ready one-hot matches chosen; bits = selected payload.
- Idle: no valids, out_ready=1 after reset: io_out_valid=0, io_chosen=3, io_in_ready=4'b1000, no state change.
- Burst lock: channel 2 sends 3 beats (last=0,0,1) while channels 0 and 3 stay valid: chosen=2 for all 3 beats; io_locked=1 after beat 1 and beat 2; after beat 3 the next grant is channel 3.
- Stall while locked: channel 1 locked, then drops valid for 2 cycles while channel 0 is valid: io_out_valid=0 and chosen=1 both cycles; the burst resumes when channel 1 re-asserts valid.
- Forced release: MAX_BEATS=4, channel 0 holds last=0 for 6 beats: io_out_last=1 on beat 4; lock drops; next grant goes to another valid channel (1 if valid).
- Backpressure and reset: out_ready=0 for 5 cycles while locked: no state change and ptr unchanged; then reset=1 for one cycle mid-burst: io_locked=0, ptr=0, and the next grant is the lowest valid index >0.

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with ready/valid ports and burst locking.
// A granted multi-beat burst holds the grant until its last beat or a beat-limit release.
module rr_lock_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BEATS = 0,
    localparam int CW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     io_in_valid,
    input  logic [N*W-1:0]   io_in_bits,
    input  logic [N-1:0]     io_in_last,
    output logic [N-1:0]     io_in_ready,
    output logic             io_out_valid,
    output logic [W-1:0]     io_out_bits,
    output logic             io_out_last,
    input  logic             io_out_ready,
    output logic [CW-1:0]    io_chosen,
    output logic             io_locked
);

    logic [CW-1:0] ptr;
    logic          locked;
    logic [CW-1:0] lock_idx;
    logic [7:0]    beat_cnt;

    logic [CW-1:0] rr_idx;
    logic          rr_found;
    logic [CW-1:0] chosen;
    logic          force_rel;
    logic          fire;
    logic          chosen_last;

    // Search above ptr first, then wrap to the lowest valid; N-1 when nothing is valid.
    always_comb begin
        rr_idx   = CW'(N - 1);
        rr_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!rr_found && io_in_valid[i] && (CW'(i) > ptr)) begin
                rr_idx   = CW'(i);
                rr_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!rr_found && io_in_valid[i]) begin
                rr_idx   = CW'(i);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        chosen       = locked ? lock_idx : rr_idx;
        force_rel    = locked && (MAX_BEATS != 0) && (beat_cnt == 8'(MAX_BEATS - 1));
        chosen_last  = io_in_last[chosen];
        io_out_valid = io_in_valid[chosen];
        io_out_bits  = io_in_bits[int'(chosen)*W +: W];
        io_out_last  = chosen_last || force_rel;
        io_chosen    = chosen;
        fire         = io_out_valid && io_out_ready;
        io_in_ready  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            io_in_ready[i] = io_out_ready && (chosen == CW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
            beat_cnt <= '0;
        end else if (fire) begin
            ptr <= chosen;
            if (chosen_last || force_rel) begin
                locked   <= 1'b0;
                beat_cnt <= '0;
            end else begin
                locked   <= 1'b1;
                lock_idx <= chosen;
                if (beat_cnt != 8'hFF) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
        end
    end

    assign io_locked = locked;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: main instance with a 4-beat release limit,
// plus an unlimited-burst instance sharing the same inputs.
module tb_rr_lock_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_bits;
    logic [N-1:0]   in_last;
    logic           out_ready;

    logic [N-1:0]   in_ready,  in_ready0;
    logic           out_valid, out_valid0;
    logic [W-1:0]   out_bits,  out_bits0;
    logic           out_last,  out_last0;
    logic [CW-1:0]  chosen,    chosen0;
    logic           locked,    locked0;

    int errors = 0;
    int checks = 0;

    rr_lock_arbiter #(.N(N), .W(W), .MAX_BEATS(4)) u_dut (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid), .io_in_bits(in_bits), .io_in_last(in_last),
        .io_in_ready(in_ready),
        .io_out_valid(out_valid), .io_out_bits(out_bits), .io_out_last(out_last),
        .io_out_ready(out_ready),
        .io_chosen(chosen), .io_locked(locked)
    );

    rr_lock_arbiter #(.N(N), .W(W), .MAX_BEATS(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid), .io_in_bits(in_bits), .io_in_last(in_last),
        .io_in_ready(in_ready0),
        .io_out_valid(out_valid0), .io_out_bits(out_bits0), .io_out_last(out_last0),
        .io_out_ready(out_ready),
        .io_chosen(chosen0), .io_locked(locked0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Full output check for a cycle that presents channel ch with downstream ready.
    task automatic grant_chk(input string tag, input int ch, input logic last_exp);
        check({tag, ".chosen"}, 32'(chosen), 32'(ch));
        check({tag, ".valid"},  32'(out_valid), 32'd1);
        check({tag, ".ready"},  32'(in_ready), 32'(1 << ch));
        check({tag, ".bits"},   32'(out_bits), 32'(8'hA0 + ch));
        check({tag, ".last"},   32'(out_last), 32'(last_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        in_bits   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid  = '0;
        in_last   = '1;
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        tick();
        settle();
        check("rst.locked", 32'(locked), 32'd0);
        check("rst.chosen", 32'(chosen), 32'd3);
        check("rst.valid",  32'(out_valid), 32'd0);
        reset = 1'b0;

        // idle
        settle();
        check("idle.valid",  32'(out_valid), 32'd0);
        check("idle.chosen", 32'(chosen), 32'd3);
        check("idle.ready",  32'(in_ready), 32'b1000);
        tick();
        check("idle.locked", 32'(locked), 32'd0);

        // fairness: ptr=0 so rotation starts at 1
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            grant_chk($sformatf("fair%0d", k), (k + 1) % 4, 1'b1);
            tick();
            check($sformatf("fair%0d.locked", k), 32'(locked), 32'd0);
        end

        // burst lock on channel 2 with 0 and 3 also valid; ptr=0
        in_valid = 4'b1101;
        in_last  = 4'b1001;
        settle();
        grant_chk("burst1", 2, 1'b0);
        tick();
        check("burst1.locked", 32'(locked), 32'd1);
        settle();
        grant_chk("burst2", 2, 1'b0);
        tick();
        check("burst2.locked", 32'(locked), 32'd1);
        in_last = 4'b1101;
        settle();
        grant_chk("burst3", 2, 1'b1);
        tick();
        check("burst3.locked", 32'(locked), 32'd0);
        settle();
        grant_chk("after_burst", 3, 1'b1);
        tick();

        // bring ptr to 0
        in_valid = 4'b0001;
        in_last  = 4'b1111;
        settle();
        grant_chk("to_ch0", 0, 1'b1);
        tick();

        // stall while channel 1 is locked
        in_valid = 4'b0011;
        in_last  = 4'b1101;
        settle();
        grant_chk("stall.start", 1, 1'b0);
        tick();
        check("stall.start.locked", 32'(locked), 32'd1);
        in_valid = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            settle();
            check($sformatf("stall%0d.valid", k),  32'(out_valid), 32'd0);
            check($sformatf("stall%0d.chosen", k), 32'(chosen), 32'd1);
            check($sformatf("stall%0d.ready", k),  32'(in_ready), 32'b0010);
            tick();
            check($sformatf("stall%0d.locked", k), 32'(locked), 32'd1);
        end
        in_valid = 4'b0011;
        in_last  = 4'b1111;
        settle();
        grant_chk("stall.resume", 1, 1'b1);
        tick();
        check("stall.resume.locked", 32'(locked), 32'd0);
        settle();
        grant_chk("stall.wrap", 0, 1'b1);
        tick();

        // forced release after 4 beats on channel 0; ptr=0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 4'b0001;
        in_last  = 4'b1110;
        settle();
        grant_chk("force.b1", 0, 1'b0);
        tick();
        in_valid = 4'b0011;
        for (int k = 2; k <= 3; k++) begin
            settle();
            grant_chk($sformatf("force.b%0d", k), 0, 1'b0);
            tick();
            check($sformatf("force.b%0d.locked", k), 32'(locked), 32'd1);
        end
        settle();
        grant_chk("force.b4", 0, 1'b1);
        check("nolimit.b4.last",   32'(out_last0), 32'd0);
        check("nolimit.b4.chosen", 32'(chosen0), 32'd0);
        tick();
        check("force.b4.locked",   32'(locked), 32'd0);
        check("nolimit.b4.locked", 32'(locked0), 32'd1);
        settle();
        grant_chk("force.next", 1, 1'b1);
        check("nolimit.held", 32'(chosen0), 32'd0);
        tick();
        in_valid = 4'b0001;
        settle();
        grant_chk("force.b5", 0, 1'b0);
        tick();
        check("force.b5.locked", 32'(locked), 32'd1);
        in_last = 4'b1111;
        settle();
        grant_chk("force.b6", 0, 1'b1);
        tick();
        check("force.b6.locked", 32'(locked), 32'd0);

        // backpressure while locked on channel 2, then reset mid-burst; ptr=0
        in_valid = 4'b0101;
        in_last  = 4'b1011;
        settle();
        grant_chk("bp.b1", 2, 1'b0);
        tick();
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("bp%0d.chosen", k), 32'(chosen), 32'd2);
            check($sformatf("bp%0d.valid", k),  32'(out_valid), 32'd1);
            check($sformatf("bp%0d.ready", k),  32'(in_ready), 32'd0);
            tick();
            check($sformatf("bp%0d.locked", k), 32'(locked), 32'd1);
        end
        out_ready = 1'b1;
        settle();
        grant_chk("bp.b2", 2, 1'b0);
        tick();
        check("bp.b2.locked", 32'(locked), 32'd1);
        reset = 1'b1;
        settle();
        check("rst_mid.chosen", 32'(chosen), 32'd2);
        check("rst_mid.locked_before", 32'(locked), 32'd1);
        tick();
        reset = 1'b0;
        in_last = 4'b1111;
        settle();
        check("rst_mid.locked", 32'(locked), 32'd0);
        grant_chk("rst_mid.next", 1, 1'b1);
        tick();
        settle();
        grant_chk("rst_mid.next2", 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
